arcade_input_mapper: RTL and testbench

- Parametrised player-input front end for arcade cores. Sits between hps_io (ps2_key, per-player joystick words) and the game core.
- Decodes PS/2 key events into held key state and merges them with joystick inputs for up to 4 players.
- Applies screen-rotation remapping and an optional SOCD (opposing-direction) cleaner.
- Generates fixed-length coin pulses, with optional auto-coin on start that holds off the start signal until the coin pulse has finished.

---
 rtl/arcade_input_mapper.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// -----------------------------------------------------------------------------
// arcade_input_mapper
//
// Player-input front end for arcade cores. It decodes PS/2 key events into held
// key state, merges that state with per-player joystick words, remaps the
// directions for screen rotation, optionally cancels opposing directions (SOCD),
// and stretches coin presses into fixed-length pulses. When auto-coin is on, a
// start press also inserts a coin, and the start is held off until that coin
// pulse has finished.
//
// Parameters
//   NPLAYERS  players supported (1..4)
//   NBTN      fire buttons per player (1..6)
//   COIN_CYC  coin pulse length in clk_sys cycles (>= 1)
//   SOCD      0 = opposing directions pass through, 1 = opposing pair -> neither
//
// Ports
//   clk_sys      in   system clock
//   reset_n      in   asynchronous active-low reset
//   ps2_key      in   [10] event toggle, [9] pressed, [8] extended, [7:0] scancode
//   joy_i        in   16-bit joystick word per player:
//                     [0] R [1] L [2] D [3] U, [4 +: NBTN] buttons,
//                     [4+NBTN] start, [5+NBTN] coin
//   rotate       in   0 none, 1 CW90, 2 CCW90, 3 rot180
//   autocoin_en  in   start press also inserts a coin
//   clear        in   synchronous release-all
//   dir_o        out  per player {up, down, left, right}
//   btn_o        out  per player fire buttons
//   start_o      out  per player start
//   coin_o       out  per player stretched coin pulse
//   service_o    out  service/test key held
// -----------------------------------------------------------------------------
module arcade_input_mapper #(
    parameter int NPLAYERS = 2,
    parameter int NBTN     = 2,
    parameter int COIN_CYC = 2400000,
    parameter int SOCD     = 1
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [10:0]              ps2_key,
    input  logic [NPLAYERS*16-1:0]   joy_i,
    input  logic [1:0]               rotate,
    input  logic                     autocoin_en,
    input  logic                     clear,
    output logic [NPLAYERS*4-1:0]    dir_o,
    output logic [NPLAYERS*NBTN-1:0] btn_o,
    output logic [NPLAYERS-1:0]      start_o,
    output logic [NPLAYERS-1:0]      coin_o,
    output logic                     service_o
);

    localparam int             CW        = $clog2(COIN_CYC + 1);
    localparam logic [CW-1:0]  COIN_LOAD = CW'(COIN_CYC);

    // Directions are carried internally in joystick bit order:
    // [3] U, [2] D, [1] L, [0] R, which is also the {up,down,left,right} output order.
    function automatic logic [3:0] rotate_dir(input logic [3:0] d, input logic [1:0] rot);
        logic [3:0] r;
        unique case (rot)
            2'd1:    r = {d[1], d[0], d[2], d[3]}; // U<-L, D<-R, L<-D, R<-U
            2'd2:    r = {d[0], d[1], d[3], d[2]}; // U<-R, D<-L, L<-U, R<-D
            2'd3:    r = {d[2], d[3], d[0], d[1]}; // U<->D, L<->R
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] socd_clean(input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (SOCD != 0) begin
            if (d[3] && d[2]) r[3:2] = 2'b00;
            if (d[1] && d[0]) r[1:0] = 2'b00;
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // PS/2 event detection
    // -------------------------------------------------------------------------
    logic       tog_q;
    logic       primed_q;
    logic       evt;
    logic [7:0] code;
    logic       ext;
    logic       pressed;

    assign code    = ps2_key[7:0];
    assign ext     = ps2_key[8];
    assign pressed = ps2_key[9];
    // primed_q masks the first cycle after reset so a toggle level left over
    // from before reset cannot be mistaken for a fresh event.
    assign evt     = primed_q & (ps2_key[10] ^ tog_q);

    // -------------------------------------------------------------------------
    // Key latches (only P1/P2 have keyboard directions and buttons)
    // -------------------------------------------------------------------------
    logic [1:0][3:0] kdir_q,   kdir_d;
    logic [1:0][5:0] kbtn_q,   kbtn_d;
    logic [3:0]      kstart_q, kstart_d;
    logic [3:0]      kcoin_q,  kcoin_d;
    logic            ksrv_q,   ksrv_d;

    // NOTE: every variable assigned in an always_comb gets a default at the top,
    // otherwise paths that skip the assignment infer a latch.
    always_comb begin
        kdir_d   = kdir_q;
        kbtn_d   = kbtn_q;
        kstart_d = kstart_q;
        kcoin_d  = kcoin_q;
        ksrv_d   = ksrv_q;
        if (clear) begin
            kdir_d   = '0;
            kbtn_d   = '0;
            kstart_d = '0;
            kcoin_d  = '0;
            ksrv_d   = 1'b0;
        end else if (evt) begin
            case (code)
                // Direction keys match regardless of the extended prefix.
                8'h75:   kdir_d[0][3] = pressed;
                8'h72:   kdir_d[0][2] = pressed;
                8'h6B:   kdir_d[0][1] = pressed;
                8'h74:   kdir_d[0][0] = pressed;
                8'h2D:   kdir_d[1][3] = pressed;
                8'h2B:   kdir_d[1][2] = pressed;
                8'h23:   kdir_d[1][1] = pressed;
                8'h34:   kdir_d[1][0] = pressed;
                default: begin
                    if (!ext) begin
                        case (code)
                            8'h14:        kbtn_d[0][0] = pressed;
                            8'h29:        kbtn_d[0][1] = pressed;
                            8'h11:        kbtn_d[0][2] = pressed;
                            8'h12:        kbtn_d[0][3] = pressed;
                            8'h1A:        kbtn_d[0][4] = pressed;
                            8'h22:        kbtn_d[0][5] = pressed;
                            8'h1C:        kbtn_d[1][0] = pressed;
                            8'h1B:        kbtn_d[1][1] = pressed;
                            8'h15:        kbtn_d[1][2] = pressed;
                            8'h1D:        kbtn_d[1][3] = pressed;
                            // E and V share P2 button 5; 0x1E is taken by start2.
                            8'h24, 8'h2A: kbtn_d[1][4] = pressed;
                            8'h21:        kbtn_d[1][5] = pressed;
                            8'h16, 8'h05: kstart_d[0]  = pressed;
                            8'h1E, 8'h06: kstart_d[1]  = pressed;
                            8'h26:        kstart_d[2]  = pressed;
                            8'h25:        kstart_d[3]  = pressed;
                            8'h2E:        kcoin_d[0]   = pressed;
                            8'h36:        kcoin_d[1]   = pressed;
                            8'h3D:        kcoin_d[2]   = pressed;
                            8'h3E:        kcoin_d[3]   = pressed;
                            8'h2C:        ksrv_d       = pressed;
                            default:      ;
                        endcase
                    end
                end
            endcase
        end
    end

    // Widen the P1/P2 key latches to four players; P3/P4 have no keys.
    logic [3:0][3:0] kdir_all;
    logic [3:0][5:0] kbtn_all;
    assign kdir_all = {8'h00, kdir_q};
    assign kbtn_all = {12'h000, kbtn_q};

    // -------------------------------------------------------------------------
    // Merge keys with joysticks
    // -------------------------------------------------------------------------
    logic [3:0]      dir_src [NPLAYERS];
    logic [NBTN-1:0] btn_src [NPLAYERS];
    logic [NPLAYERS-1:0] start_src;
    logic [NPLAYERS-1:0] coin_src;

    always_comb begin
        start_src = '0;
        coin_src  = '0;
        for (int p = 0; p < NPLAYERS; p++) begin
            dir_src[p]   = kdir_all[p] | joy_i[p*16 +: 4];
            btn_src[p]   = kbtn_all[p][NBTN-1:0] | joy_i[p*16+4 +: NBTN];
            start_src[p] = kstart_q[p] | joy_i[p*16+4+NBTN];
            coin_src[p]  = kcoin_q[p] | joy_i[p*16+5+NBTN] | (autocoin_en & start_src[p]);
        end
    end

    // -------------------------------------------------------------------------
    // Coin engine and registered outputs
    // -------------------------------------------------------------------------
    logic [CW-1:0]           cnt_q [NPLAYERS];
    logic [CW-1:0]           cnt_d [NPLAYERS];
    logic [NPLAYERS-1:0]     csrc_q, csrc_d;
    logic [NPLAYERS*4-1:0]   dir_q, dir_d;
    logic [NPLAYERS*NBTN-1:0] btn_q, btn_d;
    logic [NPLAYERS-1:0]     start_q, start_d;
    logic                    srv_q, srv_d;

    always_comb begin
        dir_d   = '0;
        btn_d   = '0;
        start_d = '0;
        srv_d   = ksrv_q;
        // Tracks coin_src even through clear, so a held source never replays.
        csrc_d  = coin_src;
        for (int p = 0; p < NPLAYERS; p++) begin
            cnt_d[p] = cnt_q[p];
            // A rising edge only loads an idle counter: no retrigger or extension.
            if (cnt_q[p] != '0)
                cnt_d[p] = cnt_q[p] - 1'b1;
            else if (coin_src[p] && !csrc_q[p])
                cnt_d[p] = COIN_LOAD;
            if (clear)
                cnt_d[p] = '0;

            dir_d[p*4 +: 4]       = socd_clean(rotate_dir(dir_src[p], rotate));
            btn_d[p*NBTN +: NBTN] = btn_src[p];
            // Gate on the next counter value so start stays low on the very
            // edge that launches the auto-coin pulse and rises as it ends.
            start_d[p] = start_src[p] & ~(autocoin_en & (cnt_d[p] != '0));
        end
        if (clear) begin
            dir_d   = '0;
            btn_d   = '0;
            start_d = '0;
            srv_d   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q    <= 1'b0;
            primed_q <= 1'b0;
            kdir_q   <= '0;
            kbtn_q   <= '0;
            kstart_q <= '0;
            kcoin_q  <= '0;
            ksrv_q   <= 1'b0;
            csrc_q   <= '0;
            dir_q    <= '0;
            btn_q    <= '0;
            start_q  <= '0;
            srv_q    <= 1'b0;
            // NOTE: the counter array is reset element by element; reset must end
            // an in-flight coin pulse immediately, so it cannot be left uninitialised.
            for (int p = 0; p < NPLAYERS; p++) cnt_q[p] <= '0;
        end else begin
            tog_q    <= ps2_key[10];
            primed_q <= 1'b1;
            kdir_q   <= kdir_d;
            kbtn_q   <= kbtn_d;
            kstart_q <= kstart_d;
            kcoin_q  <= kcoin_d;
            ksrv_q   <= ksrv_d;
            csrc_q   <= csrc_d;
            dir_q    <= dir_d;
            btn_q    <= btn_d;
            start_q  <= start_d;
            srv_q    <= srv_d;
            for (int p = 0; p < NPLAYERS; p++) cnt_q[p] <= cnt_d[p];
        end
    end

    always_comb begin
        coin_o = '0;
        for (int p = 0; p < NPLAYERS; p++) coin_o[p] = (cnt_q[p] != '0);
    end

    assign dir_o     = dir_q;
    assign btn_o     = btn_q;
    assign start_o   = start_q;
    assign service_o = srv_q;

    // Joystick padding bits and latches for absent players/buttons are not used.
    logic unused_bits;
    assign unused_bits = ^{joy_i, kdir_all, kbtn_all, kstart_q, kcoin_q};

endmodule

// File: tb/tb_arcade_input_mapper.sv
module tb_arcade_input_mapper;

    localparam int NP   = 2;
    localparam int NB   = 2;
    localparam int CYC  = 8;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic [10:0]       ps2_key;
    logic [NP*16-1:0]  joy_i;
    logic [1:0]        rotate;
    logic              autocoin_en;
    logic              clear;
    logic [NP*4-1:0]   dir_o;
    logic [NP*NB-1:0]  btn_o;
    logic [NP-1:0]     start_o;
    logic [NP-1:0]     coin_o;
    logic              service_o;

    arcade_input_mapper #(
        .NPLAYERS (NP),
        .NBTN     (NB),
        .COIN_CYC (CYC),
        .SOCD     (1)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_key     (ps2_key),
        .joy_i       (joy_i),
        .rotate      (rotate),
        .autocoin_en (autocoin_en),
        .clear       (clear),
        .dir_o       (dir_o),
        .btn_o       (btn_o),
        .start_o     (start_o),
        .coin_o      (coin_o),
        .service_o   (service_o)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         at;
        logic [7:0] dir;
        logic [3:0] btn;
        logic [1:0] start;
        logic [1:0] coin;
        logic       srv;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic push_exp(input string name, input int dly, input logic [7:0] dir,
                            input logic [3:0] btn, input logic [1:0] st,
                            input logic [1:0] cn, input logic srv);
        exp_t e;
        e.name  = name;
        e.at    = cyc + dly;
        e.dir   = dir;
        e.btn   = btn;
        e.start = st;
        e.coin  = cn;
        e.srv   = srv;
        sb.push_back(e);
    endtask

    task automatic check(input exp_t e);
        compared++;
        if (dir_o !== e.dir || btn_o !== e.btn || start_o !== e.start ||
            coin_o !== e.coin || service_o !== e.srv) begin
            mismatched++;
            $display("FAIL %s @cyc %0d: got dir=%h btn=%h start=%b coin=%b srv=%b, want dir=%h btn=%h start=%b coin=%b srv=%b",
                     e.name, cyc, dir_o, btn_o, start_o, coin_o, service_o,
                     e.dir, e.btn, e.start, e.coin, e.srv);
        end
    endtask

    // Monitor: outputs are registered, so sample on the falling edge and
    // retire every scoreboard entry due on this cycle.
    always @(negedge clk_sys) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                check(sb[i]);
                sb.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // code9 = {extended, scancode}; every call flips the event toggle.
    task automatic ps2(input logic [8:0] code9, input logic pr);
        ps2_key = {~ps2_key[10], pr, code9};
    endtask

    initial begin
        reset_n     = 1'b0;
        ps2_key     = 11'h475;
        joy_i       = '0;
        rotate      = 2'd0;
        autocoin_en = 1'b0;
        clear       = 1'b0;

        step(2);
        push_exp("reset_state", 1, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(1);
        reset_n = 1'b1;

        // Stale toggle held through reset must not produce an event.
        step(3);
        push_exp("stale_toggle", 1, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(1);
        ps2_key = 11'h075;
        push_exp("stale_release", 2, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(4);
        ps2_key = 11'h675;
        push_exp("up_latch_only", 1, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        push_exp("up_one_cycle", 2, 8'h08, 4'h0, 2'b00, 2'b00, 1'b0);
        step(3);
        ps2(9'h075, 1'b0);
        push_exp("up_release", 2, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(3);

        // Rotation of a held P1 left arrow.
        ps2(9'h16B, 1'b1);
        step(3);
        push_exp("left_rot0", 1, 8'h02, 4'h0, 2'b00, 2'b00, 1'b0);
        step(2);
        rotate = 2'd1;
        push_exp("left_rot_cw", 1, 8'h08, 4'h0, 2'b00, 2'b00, 1'b0);
        step(2);
        rotate = 2'd2;
        push_exp("left_rot_ccw", 1, 8'h04, 4'h0, 2'b00, 2'b00, 1'b0);
        step(2);
        rotate = 2'd3;
        push_exp("left_rot_180", 1, 8'h01, 4'h0, 2'b00, 2'b00, 1'b0);
        step(2);
        rotate = 2'd0;
        ps2(9'h16B, 1'b0);
        push_exp("left_release", 2, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(3);

        // SOCD cleaning and joystick merge.
        joy_i = 32'h0000_000C;
        push_exp("socd_ud", 1, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(2);
        joy_i = 32'h0000_000E;
        push_exp("socd_ud_l", 1, 8'h02, 4'h0, 2'b00, 2'b00, 1'b0);
        step(2);
        joy_i = 32'h0000_000F;
        push_exp("socd_all", 1, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(2);
        joy_i  = 32'h0018_0030;
        rotate = 2'd3;
        push_exp("joy_p2_rot180", 1, 8'h40, 4'h7, 2'b00, 2'b00, 1'b0);
        step(2);
        joy_i  = '0;
        rotate = 2'd0;
        push_exp("joy_idle", 1, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(2);
        joy_i = 32'h0040_0000;
        push_exp("joy_start2", 1, 8'h00, 4'h0, 2'b10, 2'b00, 1'b0);
        step(2);
        joy_i = '0;
        step(2);

        // Extended prefix on a non-direction code is ignored.
        ps2(9'h114, 1'b1);
        push_exp("ext_ctrl_ignored", 2, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(3);
        ps2(9'h114, 1'b0);
        step(2);

        // Coin pulse: 8 cycles, re-press while busy ignored, hold never retriggers.
        ps2(9'h02E, 1'b1);
        push_exp("coin_pre", 1, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        push_exp("coin_rise", 2, 8'h00, 4'h0, 2'b00, 2'b01, 1'b0);
        push_exp("coin_mid", 5, 8'h00, 4'h0, 2'b00, 2'b01, 1'b0);
        push_exp("coin_last", 9, 8'h00, 4'h0, 2'b00, 2'b01, 1'b0);
        push_exp("coin_end", 10, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        push_exp("coin_held", 14, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        push_exp("coin_held_late", 20, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(2);
        ps2(9'h02E, 1'b0);
        step(2);
        ps2(9'h02E, 1'b1);
        step(20);
        ps2(9'h02E, 1'b0);
        step(3);

        // Auto-coin: start held off while the coin pulse runs.
        autocoin_en = 1'b1;
        ps2(9'h016, 1'b1);
        push_exp("ac_pre", 1, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        push_exp("ac_coin_rise", 2, 8'h00, 4'h0, 2'b00, 2'b01, 1'b0);
        push_exp("ac_mid", 5, 8'h00, 4'h0, 2'b00, 2'b01, 1'b0);
        push_exp("ac_coin_last", 9, 8'h00, 4'h0, 2'b00, 2'b01, 1'b0);
        push_exp("ac_start_on", 10, 8'h00, 4'h0, 2'b01, 2'b00, 1'b0);
        push_exp("ac_start_held", 15, 8'h00, 4'h0, 2'b01, 2'b00, 1'b0);
        step(15);
        ps2(9'h016, 1'b0);
        push_exp("ac_release", 2, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(3);
        autocoin_en = 1'b0;
        step(1);

        // Without auto-coin, start passes straight through.
        ps2(9'h016, 1'b1);
        push_exp("noac_pre", 1, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        push_exp("noac_start", 2, 8'h00, 4'h0, 2'b01, 2'b00, 1'b0);
        push_exp("noac_held", 6, 8'h00, 4'h0, 2'b01, 2'b00, 1'b0);
        step(6);
        ps2(9'h016, 1'b0);
        push_exp("noac_release", 2, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(3);

        // F2 alias for start2, then service key.
        ps2(9'h006, 1'b1);
        push_exp("f2_start2", 2, 8'h00, 4'h0, 2'b10, 2'b00, 1'b0);
        step(3);
        ps2(9'h006, 1'b0);
        push_exp("f2_release", 2, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(3);
        ps2(9'h02C, 1'b1);
        push_exp("service_on", 2, 8'h00, 4'h0, 2'b00, 2'b00, 1'b1);
        step(3);
        ps2(9'h02C, 1'b0);
        push_exp("service_off", 2, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(3);

        // Clear with P2 fire held and a P2 coin pulse running.
        ps2(9'h01C, 1'b1);
        step(2);
        ps2(9'h036, 1'b1);
        step(4);
        push_exp("pre_clear", 1, 8'h00, 4'h4, 2'b00, 2'b10, 1'b0);
        step(1);
        clear = 1'b1;
        push_exp("clear_next", 1, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(1);
        clear = 1'b0;
        push_exp("clear_stays", 3, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        push_exp("clear_no_coin", 6, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(8);
        ps2(9'h01C, 1'b0);
        step(2);
        ps2(9'h036, 1'b0);
        step(3);

        // Reset mid-pulse clears the coin output asynchronously.
        ps2(9'h02E, 1'b1);
        step(4);
        push_exp("rst_pre", 1, 8'h00, 4'h0, 2'b00, 2'b01, 1'b0);
        step(1);
        #2;
        reset_n = 1'b0;
        push_exp("rst_async", 1, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(3);
        reset_n = 1'b1;
        push_exp("post_rst_idle", 3, 8'h00, 4'h0, 2'b00, 2'b00, 1'b0);
        step(5);
        ps2(9'h02E, 1'b0);
        step(3);

        for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
        while (sb.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s: never sampled (due cyc %0d, now %0d)", sb[0].name, sb[0].at, cyc);
            void'(sb.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
